// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and helpers for the hazard scoreboard
// Purpose: forwarding-select encodings, the "operand not read" Tuse marker
//          and the saturating Tnew decrement used by the shadow slots.
// Ports:   none (package)
package hazard_pkg;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EX    = 2'b01;
  localparam logic [1:0] FWD_MEM   = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b11;

  localparam logic [1:0] TUSE_NONE = 2'b11;

  // Tnew counts down as an instruction moves toward WB and bottoms out at 0.
  function automatic logic [7:0] sat_dec(input logic [7:0] t);
    return (t == 8'd0) ? 8'd0 : t - 8'd1;
  endfunction

endpackage

// File: rtl/hz_slot.sv
// rtl/hz_slot.sv - one pipeline-stage shadow of {A1, A2, A3, Tnew, RegWrite}
// Purpose: registers the producer info of one pipeline stage. A flush loads
//          an empty slot (bubble); DEC_TNEW ages Tnew by one on the way in.
// Ports:   clk, rst        clock, synchronous active-high reset
//          flush           load an empty slot instead of the inputs
//          *_in            slot contents from the previous stage
//          a1/a2/a3/tnew/regwrite  current slot contents
module hz_slot #(
  parameter int REG_AW   = 5,
  parameter int TW       = 2,
  parameter bit DEC_TNEW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [REG_AW-1:0] a1_in,
  input  logic [REG_AW-1:0] a2_in,
  input  logic [REG_AW-1:0] a3_in,
  input  logic [TW-1:0]     tnew_in,
  input  logic              regwrite_in,
  output logic [REG_AW-1:0] a1,
  output logic [REG_AW-1:0] a2,
  output logic [REG_AW-1:0] a3,
  output logic [TW-1:0]     tnew,
  output logic              regwrite
);
  import hazard_pkg::*;

  logic [REG_AW-1:0] a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [TW-1:0]     tnew_q, tnew_d;
  logic              regwrite_q, regwrite_d;

  always_comb begin
    a1_d       = a1_in;
    a2_d       = a2_in;
    a3_d       = a3_in;
    tnew_d     = DEC_TNEW ? TW'(sat_dec(8'(tnew_in))) : tnew_in;
    regwrite_d = regwrite_in;
    if (flush) begin
      a1_d       = '0;
      a2_d       = '0;
      a3_d       = '0;
      tnew_d     = '0;
      regwrite_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a1_q       <= '0;
      a2_q       <= '0;
      a3_q       <= '0;
      tnew_q     <= '0;
      regwrite_q <= 1'b0;
    end else begin
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      a3_q       <= a3_d;
      tnew_q     <= tnew_d;
      regwrite_q <= regwrite_d;
    end
  end

  assign a1       = a1_q;
  assign a2       = a2_q;
  assign a3       = a3_q;
  assign tnew     = tnew_q;
  assign regwrite = regwrite_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - stall and forwarding producer for the 5-stage pipeline
// Purpose: shadows EX/MEM/WB producers, compares them against the ID-stage
//          reads and their Tuse, and drives stall, forwarding selects and a
//          saturating stall-cycle counter.
// Ports:   clk, rst                 clock, synchronous active-high reset
//          A1_ID/A2_ID, Tuse_rs/rt  ID source registers and when they are used
//          A3_ID, Tnew_ID, RegWrite_ID  ID destination info
//          stall                    freeze PC/IF-ID, bubble into ID/EX
//          fwd_rs/rt_ID, fwd_rs/rt_EX  forwarding selects
//          stall_cnt                stall-cycle count
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] A1_ID,
  input  logic [REG_AW-1:0] A2_ID,
  input  logic [TW-1:0]     Tuse_rs,
  input  logic [TW-1:0]     Tuse_rt,
  input  logic [REG_AW-1:0] A3_ID,
  input  logic [TW-1:0]     Tnew_ID,
  input  logic              RegWrite_ID,
  output logic              stall,
  output logic [1:0]        fwd_rs_ID,
  output logic [1:0]        fwd_rt_ID,
  output logic [1:0]        fwd_rs_EX,
  output logic [1:0]        fwd_rt_EX,
  output logic [CNT_W-1:0]  stall_cnt
);
  import hazard_pkg::*;

  logic [REG_AW-1:0] a1_ex, a2_ex, a3_ex, a1_mem, a2_mem, a3_mem, a1_wb, a2_wb, a3_wb;
  logic [TW-1:0]     tnew_ex, tnew_mem, tnew_wb;
  logic              rw_ex, rw_mem, rw_wb;
  logic              live_ex, live_mem, live_wb;
  logic              rs_used, rt_used, rs_term, rt_term;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              unused_slot_bits;

  hz_slot #(.REG_AW(REG_AW), .TW(TW), .DEC_TNEW(1'b0)) u_ex (
    .clk(clk), .rst(rst), .flush(stall),
    .a1_in(A1_ID), .a2_in(A2_ID), .a3_in(A3_ID), .tnew_in(Tnew_ID), .regwrite_in(RegWrite_ID),
    .a1(a1_ex), .a2(a2_ex), .a3(a3_ex), .tnew(tnew_ex), .regwrite(rw_ex)
  );

  hz_slot #(.REG_AW(REG_AW), .TW(TW), .DEC_TNEW(1'b1)) u_mem (
    .clk(clk), .rst(rst), .flush(1'b0),
    .a1_in(a1_ex), .a2_in(a2_ex), .a3_in(a3_ex), .tnew_in(tnew_ex), .regwrite_in(rw_ex),
    .a1(a1_mem), .a2(a2_mem), .a3(a3_mem), .tnew(tnew_mem), .regwrite(rw_mem)
  );

  hz_slot #(.REG_AW(REG_AW), .TW(TW), .DEC_TNEW(1'b1)) u_wb (
    .clk(clk), .rst(rst), .flush(1'b0),
    .a1_in(a1_mem), .a2_in(a2_mem), .a3_in(a3_mem), .tnew_in(tnew_mem), .regwrite_in(rw_mem),
    .a1(a1_wb), .a2(a2_wb), .a3(a3_wb), .tnew(tnew_wb), .regwrite(rw_wb)
  );

  // Source addresses of MEM/WB are only carried so the EX slot can hand them on.
  assign unused_slot_bits = ^{a1_mem, a2_mem, a1_wb, a2_wb};

  // $0 is never a live producer, so a match also implies a non-zero source.
  assign live_ex  = rw_ex  && (a3_ex  != '0);
  assign live_mem = rw_mem && (a3_mem != '0);
  assign live_wb  = rw_wb  && (a3_wb  != '0);

  assign rs_used = (Tuse_rs != TW'(TUSE_NONE)) && (A1_ID != '0);
  assign rt_used = (Tuse_rt != TW'(TUSE_NONE)) && (A2_ID != '0);

  assign rs_term = rs_used && ((live_ex  && a3_ex  == A1_ID && tnew_ex  > Tuse_rs) ||
                               (live_mem && a3_mem == A1_ID && tnew_mem > Tuse_rs));
  assign rt_term = rt_used && ((live_ex  && a3_ex  == A2_ID && tnew_ex  > Tuse_rt) ||
                               (live_mem && a3_mem == A2_ID && tnew_mem > Tuse_rt));
  assign stall   = rs_term | rt_term;

  // Youngest matching producer wins; if its value is not ready yet, read the
  // normal path and let the stall hold the consumer.
  function automatic logic [1:0] pick(input logic hit_ex, input logic hit_mem, input logic hit_wb,
                                      input logic rdy_ex, input logic rdy_mem, input logic rdy_wb);
    if (hit_ex)       return rdy_ex  ? FWD_EX  : FWD_NONE;
    else if (hit_mem) return rdy_mem ? FWD_MEM : FWD_NONE;
    else if (hit_wb)  return rdy_wb  ? FWD_WB  : FWD_NONE;
    else              return FWD_NONE;
  endfunction

  always_comb begin
    fwd_rs_ID = FWD_NONE;
    fwd_rt_ID = FWD_NONE;
    if (Tuse_rs != TW'(TUSE_NONE))
      fwd_rs_ID = pick(live_ex && a3_ex == A1_ID, live_mem && a3_mem == A1_ID, live_wb && a3_wb == A1_ID,
                       tnew_ex == '0, tnew_mem == '0, tnew_wb == '0);
    if (Tuse_rt != TW'(TUSE_NONE))
      fwd_rt_ID = pick(live_ex && a3_ex == A2_ID, live_mem && a3_mem == A2_ID, live_wb && a3_wb == A2_ID,
                       tnew_ex == '0, tnew_mem == '0, tnew_wb == '0);
    fwd_rs_EX = pick(1'b0, live_mem && a3_mem == a1_ex, live_wb && a3_wb == a1_ex,
                     1'b0, tnew_mem == '0, tnew_wb == '0);
    fwd_rt_EX = pick(1'b0, live_mem && a3_mem == a2_ex, live_wb && a3_wb == a2_ex,
                     1'b0, tnew_mem == '0, tnew_wb == '0);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  A1_ID, A2_ID, A3_ID;
  logic [1:0]  Tuse_rs, Tuse_rt, Tnew_ID;
  logic        RegWrite_ID;
  logic        stall, stall_s;
  logic [1:0]  fwd_rs_ID, fwd_rt_ID, fwd_rs_EX, fwd_rt_EX;
  logic [1:0]  fwd_rs_ID_s, fwd_rt_ID_s, fwd_rs_EX_s, fwd_rt_EX_s;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .A1_ID(A1_ID), .A2_ID(A2_ID), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
    .A3_ID(A3_ID), .Tnew_ID(Tnew_ID), .RegWrite_ID(RegWrite_ID), .stall(stall),
    .fwd_rs_ID(fwd_rs_ID), .fwd_rt_ID(fwd_rt_ID), .fwd_rs_EX(fwd_rs_EX), .fwd_rt_EX(fwd_rt_EX),
    .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .A1_ID(A1_ID), .A2_ID(A2_ID), .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
    .A3_ID(A3_ID), .Tnew_ID(Tnew_ID), .RegWrite_ID(RegWrite_ID), .stall(stall_s),
    .fwd_rs_ID(fwd_rs_ID_s), .fwd_rt_ID(fwd_rt_ID_s), .fwd_rs_EX(fwd_rs_EX_s), .fwd_rt_EX(fwd_rt_EX_s),
    .stall_cnt(stall_cnt_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int a1, input int a2, input int tur, input int tut,
                       input int a3, input int tn, input int rw);
    A1_ID       = 5'(a1);
    A2_ID       = 5'(a2);
    Tuse_rs     = 2'(tur);
    Tuse_rt     = 2'(tut);
    A3_ID       = 5'(a3);
    Tnew_ID     = 2'(tn);
    RegWrite_ID = 1'(rw);
    #1;
  endtask

  task automatic idle();
    issue(0, 0, 3, 3, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    do_reset();
    check_eq("rst_stall", stall, 0);
    check_eq("rst_fwd_rs_ID", fwd_rs_ID, 0);
    check_eq("rst_fwd_rt_ID", fwd_rt_ID, 0);
    check_eq("rst_fwd_rs_EX", fwd_rs_EX, 0);
    check_eq("rst_fwd_rt_EX", fwd_rt_EX, 0);
    check_eq("rst_cnt", stall_cnt, 0);

    // lw $8 then add $9,$8,$1 (Tuse 1): one stall, load reaches WB when add is in EX
    issue(1, 0, 1, 3, 8, 2, 1);
    check_eq("lu_no_stall_lw", stall, 0);
    step();
    issue(8, 1, 1, 1, 9, 1, 1);
    check_eq("lu_stall", stall, 1);
    check_eq("lu_fwd_rs_ID_wait", fwd_rs_ID, 0);
    step();
    check_eq("lu_stall_end", stall, 0);
    check_eq("lu_cnt", stall_cnt, 1);
    step();
    idle();
    check_eq("lu_fwd_rs_EX", fwd_rs_EX, 2'b11);

    // add $8 then beq $8,$0 (Tuse 0)
    do_reset();
    issue(2, 3, 1, 1, 8, 1, 1);
    step();
    issue(8, 0, 0, 0, 0, 0, 0);
    check_eq("br_stall", stall, 1);
    step();
    check_eq("br_stall_end", stall, 0);
    check_eq("br_fwd_rs_ID", fwd_rs_ID, 2'b10);
    check_eq("br_fwd_rt_ID", fwd_rt_ID, 2'b00);
    check_eq("br_cnt", stall_cnt, 1);

    // jal $31 then jr $31
    do_reset();
    issue(0, 0, 3, 3, 31, 0, 1);
    step();
    issue(31, 0, 0, 3, 0, 0, 0);
    check_eq("jr_stall", stall, 0);
    check_eq("jr_fwd_rs_ID", fwd_rs_ID, 2'b01);

    // ori $0 then add reading $0 on both operands
    do_reset();
    issue(1, 0, 1, 3, 0, 1, 1);
    step();
    issue(0, 0, 1, 1, 10, 1, 1);
    check_eq("r0_stall", stall, 0);
    check_eq("r0_fwd_rs_ID", fwd_rs_ID, 0);
    check_eq("r0_fwd_rt_ID", fwd_rt_ID, 0);
    step();
    idle();
    check_eq("r0_fwd_rs_EX", fwd_rs_EX, 0);
    check_eq("r0_fwd_rt_EX", fwd_rt_EX, 0);

    // $8 written twice in a row: MEM beats WB for the EX operand
    do_reset();
    issue(1, 2, 1, 1, 8, 1, 1);
    step();
    issue(1, 2, 1, 1, 8, 1, 1);
    step();
    issue(8, 8, 1, 1, 9, 1, 1);
    check_eq("pri_stall", stall, 0);
    check_eq("pri_fwd_rs_ID", fwd_rs_ID, 0);
    step();
    idle();
    check_eq("pri_fwd_rs_EX", fwd_rs_EX, 2'b10);
    check_eq("pri_fwd_rt_EX", fwd_rt_EX, 2'b10);

    // back-to-back loads, second uses first at Tuse 0
    do_reset();
    issue(1, 0, 1, 3, 8, 2, 1);
    step();
    issue(8, 0, 0, 3, 9, 2, 1);
    check_eq("ll_stall_1", stall, 1);
    step();
    check_eq("ll_stall_2", stall, 1);
    step();
    check_eq("ll_stall_end", stall, 0);
    check_eq("ll_fwd_rs_ID", fwd_rs_ID, 2'b11);
    check_eq("ll_cnt", stall_cnt, 2);

    // reset in the middle of a load-use stall
    do_reset();
    issue(1, 0, 1, 3, 8, 2, 1);
    step();
    issue(8, 0, 0, 3, 9, 2, 1);
    step();
    check_eq("rm_pre_stall", stall, 1);
    check_eq("rm_pre_cnt", stall_cnt, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rm_stall", stall, 0);
    check_eq("rm_cnt", stall_cnt, 0);
    check_eq("rm_fwd_rs_ID", fwd_rs_ID, 0);

    // 20 stall cycles: 4-bit counter saturates at 15
    do_reset();
    for (int i = 0; i < 10; i++) begin
      issue(1, 0, 1, 3, 8, 2, 1);
      step();
      issue(8, 0, 0, 3, 0, 0, 0);
      step();
      step();
      step();
    end
    idle();
    check_eq("sat_cnt_wide", stall_cnt, 20);
    check_eq("sat_cnt_4b", 32'(stall_cnt_s), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
